fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port rom_ce_o, output, 1 bit: instruction ROM chip enable; 1 = fetch this cycle.
REQ-005 The block SHALL have port rom_addr_o, output, 32 bits: byte address sent to the ROM.
REQ-006 The block SHALL have port rom_inst_i, input, 32 bits: instruction word returned combinationally by the ROM in the same cycle.
REQ-007 The block SHALL have port branch_flag_i, input, 1 bit: redirect request.
REQ-008 The block SHALL have port branch_target_i, input, 32 bits: redirect byte address.
REQ-009 The block SHALL have port id_valid_o, output, 1 bit: the queue head is valid for decode.
REQ-010 The block SHALL have port id_ready_i, input, 1 bit: decode accepts the head this cycle.
REQ-011 The block SHALL have port id_pc_o, output, 32 bits: byte address of the head instruction.
REQ-012 The block SHALL have port id_inst_o, output, 32 bits: head instruction word.

Function
REQ-013 The block SHALL hold a 32-bit pc register, a 2-entry FIFO of {pc, inst} pairs, and a 2-bit occupancy count (0..2).
REQ-014 The block SHALL have two states, RESET and RUN: rst=1 enters RESET; the first edge with rst=0 moves to RUN; RUN persists until rst=1.
REQ-015 rom_addr_o SHALL equal pc at all times.
REQ-016 rom_ce_o SHALL be 1 iff the state is RUN and count < 2; a full queue does not fetch, even when a pop occurs in the same cycle (one-cycle bubble).
REQ-017 fetch = rom_ce_o AND NOT branch_flag_i: on that edge the block SHALL push {pc, rom_inst_i} at the tail and set pc <= pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-018 pop = id_valid_o AND id_ready_i: on that edge the head entry SHALL be removed.
REQ-019 On a simultaneous push and pop the count SHALL be unchanged, and entry order SHALL be preserved (FIFO).
REQ-020 id_valid_o SHALL be 1 iff count > 0; id_pc_o/id_inst_o SHALL show the head entry, and 0 when count = 0.
REQ-021 Fetch-to-decode latency SHALL be 1 cycle: an instruction fetched at edge N is visible at the head after edge N when the queue was empty.
REQ-022 When branch_flag_i=1 in RUN, on that edge: count <= 0, pc <= {branch_target_i[31:2], 2'b00}, no push; a pop in that cycle is still a completed handshake.
REQ-023 Branch SHALL take priority over both push and pop for updating queue contents; the first fetch from the target occurs the cycle after the redirect.
REQ-024 branch_flag_i SHALL be ignored in RESET state and while rst=1.
REQ-025 id_valid_o SHALL NOT depend combinationally on id_ready_i; rom_ce_o SHALL NOT depend combinationally on branch_flag_i or id_ready_i.

Reset
REQ-026 While rst=1, on each edge: pc <= RESET_PC, count <= 0, state <= RESET, and FIFO data <= 0.
REQ-027 During and after reset until RUN: rom_ce_o=0, rom_addr_o=RESET_PC, id_valid_o=0, id_pc_o=0, id_inst_o=0.
REQ-028 Reset asserted mid-operation SHALL discard all queued entries and any in-flight redirect on the same edge.

Verification
REQ-029 Release rst with RESET_PC=0 and id_ready_i=1, ROM word[a]=a: id_pc_o/id_inst_o SHALL stream 0,4,8,... one per cycle starting the second cycle after release.
REQ-030 Hold id_ready_i=0: after two fetches (pc 0,4), rom_ce_o SHALL be 0 and pc SHALL hold 8; raising id_ready_i SHALL pop 0 then 4, with fetch of 8 resuming once count < 2.
REQ-031 Assert branch_flag_i with target 32'h0000_0103 while count=2: the next cycle SHALL show id_valid_o=0 and rom_addr_o=32'h100, and the following cycle id_pc_o=32'h100.
REQ-032 Set RESET_PC=32'hFFFF_FFF8: fetched addresses SHALL be FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-033 Assert rst for one cycle with count=2: the queue SHALL empty, id_valid_o=0, and fetch SHALL restart at RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch front end: drives the ROM from a pc register and buffers {pc, inst} in a 2-entry FIFO for decode.
// Latency 1 cycle fetch-to-head; full queue stops fetching, branch flushes the queue and redirects pc.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_inst_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o
);

    typedef enum logic {
        S_RESET = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [1:0]  count;
    entry_t      head;
    entry_t      tail;
    entry_t      fetched;
    logic        redirect;
    logic        fetch;
    logic        pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RESET;
        end else begin
            state <= state_next;
        end
    end

    // Fetch enable looks only at state and occupancy, never at branch or ready.
    always_comb begin
        state_next = state;
        rom_ce_o   = 1'b0;
        redirect   = 1'b0;
        case (state)
            S_RESET: state_next = S_RUN;
            S_RUN: begin
                rom_ce_o = (count < 2'd2);
                redirect = branch_flag_i;
            end
            default: state_next = S_RESET;
        endcase
    end

    assign fetch      = rom_ce_o && !branch_flag_i;
    assign pop        = id_valid_o && id_ready_i;
    assign fetched    = '{pc: pc, inst: rom_inst_i};
    assign rom_addr_o = pc;
    assign id_valid_o = (count != 2'd0);
    assign id_pc_o    = id_valid_o ? head.pc : 32'h0;
    assign id_inst_o  = id_valid_o ? head.inst : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_PC;
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else if (redirect) begin
            pc    <= branch_target_i & ~32'h3;
            count <= 2'd0;
        end else begin
            if (fetch) begin
                pc <= pc + 32'd4;
            end
            case ({fetch, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= fetched;
                    end else begin
                        tail <= fetched;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                // Push with pop only happens at count 1, so the new entry becomes the head.
                2'b11: head <= fetched;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, backpressure, branch flush, pc wrap and mid-run reset.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_inst_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic [31:0] rom_xor;

    logic        w_ce;
    logic [31:0] w_addr;
    logic        w_valid;
    logic [31:0] w_pc;
    logic [31:0] w_inst;
    logic        w_branch;
    logic [31:0] w_target;
    logic        w_ready;

    int total;
    int bad;

    assign rom_inst_i = rom_addr_o ^ rom_xor;

    fetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .rom_ce_o       (rom_ce_o),
        .rom_addr_o     (rom_addr_o),
        .rom_inst_i     (rom_inst_i),
        .branch_flag_i  (branch_flag_i),
        .branch_target_i(branch_target_i),
        .id_valid_o     (id_valid_o),
        .id_ready_i     (id_ready_i),
        .id_pc_o        (id_pc_o),
        .id_inst_o      (id_inst_o)
    );

    fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk            (clk),
        .rst            (rst),
        .rom_ce_o       (w_ce),
        .rom_addr_o     (w_addr),
        .rom_inst_i     (w_addr),
        .branch_flag_i  (w_branch),
        .branch_target_i(w_target),
        .id_valid_o     (w_valid),
        .id_ready_i     (w_ready),
        .id_pc_o        (w_pc),
        .id_inst_o      (w_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        logic [31:0] wexp;
        total = 0;
        bad = 0;
        rst = 1'b1;
        rom_xor = 32'h0;
        branch_flag_i = 1'b0;
        branch_target_i = 32'h0;
        id_ready_i = 1'b1;
        w_branch = 1'b0;
        w_target = 32'h0;
        w_ready = 1'b1;
        step();
        step();

        check("rst_ce", {31'h0, rom_ce_o}, 32'h0);
        check("rst_addr", rom_addr_o, 32'h0);
        check("rst_valid", {31'h0, id_valid_o}, 32'h0);
        check("rst_pc", id_pc_o, 32'h0);
        check("rst_inst", id_inst_o, 32'h0);
        check("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);

        // Streaming with ready held high; the wrap instance runs alongside.
        rst = 1'b0;
        step();
        check("run_ce", {31'h0, rom_ce_o}, 32'h1);
        check("run_valid", {31'h0, id_valid_o}, 32'h0);
        step();
        for (int k = 0; k < 4; k++) begin
            check("stream_valid", {31'h0, id_valid_o}, 32'h1);
            check("stream_pc", id_pc_o, 32'(4 * k));
            check("stream_inst", id_inst_o, 32'(4 * k));
            wexp = 32'hFFFF_FFF8 + 32'(4 * k);
            check("wrap_pc", w_pc, wexp);
            step();
        end

        // Backpressure: two fetches fill the queue, then fetch stalls at pc 8.
        rom_xor = 32'h5A00_0000;
        id_ready_i = 1'b0;
        do_reset();
        step();
        check("bp_valid", {31'h0, id_valid_o}, 32'h1);
        check("bp_ce1", {31'h0, rom_ce_o}, 32'h1);
        step();
        check("bp_full_ce", {31'h0, rom_ce_o}, 32'h0);
        check("bp_full_addr", rom_addr_o, 32'h8);
        check("bp_head", id_pc_o, 32'h0);
        step();
        check("bp_hold_ce", {31'h0, rom_ce_o}, 32'h0);
        check("bp_hold_addr", rom_addr_o, 32'h8);
        id_ready_i = 1'b1;
        step();
        check("bp_pop1_pc", id_pc_o, 32'h4);
        check("bp_pop1_inst", id_inst_o, 32'h5A00_0004);
        check("bp_resume_ce", {31'h0, rom_ce_o}, 32'h1);
        step();
        check("bp_pop2_pc", id_pc_o, 32'h8);
        check("bp_addr_c", rom_addr_o, 32'hC);

        // Branch while full, with a pop in the same cycle.
        id_ready_i = 1'b0;
        do_reset();
        step();
        step();
        check("br_full_ce", {31'h0, rom_ce_o}, 32'h0);
        branch_flag_i = 1'b1;
        branch_target_i = 32'h0000_0103;
        id_ready_i = 1'b1;
        step();
        branch_flag_i = 1'b0;
        check("br_valid", {31'h0, id_valid_o}, 32'h0);
        check("br_addr", rom_addr_o, 32'h100);
        check("br_ce", {31'h0, rom_ce_o}, 32'h1);
        check("br_pc_zero", id_pc_o, 32'h0);
        step();
        check("br_tgt_valid", {31'h0, id_valid_o}, 32'h1);
        check("br_tgt_pc", id_pc_o, 32'h100);
        check("br_tgt_inst", id_inst_o, 32'h5A00_0100);
        check("br_next_addr", rom_addr_o, 32'h104);

        // Reset while full with a redirect pending; redirect ignored through release.
        id_ready_i = 1'b0;
        step();
        check("mr_full_ce", {31'h0, rom_ce_o}, 32'h0);
        check("mr_full_valid", {31'h0, id_valid_o}, 32'h1);
        rst = 1'b1;
        branch_flag_i = 1'b1;
        branch_target_i = 32'h0000_0200;
        step();
        check("mr_valid", {31'h0, id_valid_o}, 32'h0);
        check("mr_pc", id_pc_o, 32'h0);
        check("mr_inst", id_inst_o, 32'h0);
        check("mr_addr", rom_addr_o, 32'h0);
        rst = 1'b0;
        step();
        check("mr_rel_addr", rom_addr_o, 32'h0);
        check("mr_rel_ce", {31'h0, rom_ce_o}, 32'h1);
        branch_flag_i = 1'b0;
        id_ready_i = 1'b1;
        step();
        check("mr_first_pc", id_pc_o, 32'h0);
        check("mr_first_valid", {31'h0, id_valid_o}, 32'h1);
        check("mr_next_addr", rom_addr_o, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
